// File: rtl/btn_debounce_intr_if.sv
// rtl/btn_debounce_intr_if.sv - button conditioner signal bundle
interface btn_debounce_intr_if;
  logic       BTN_IN;
  logic       CLR_COUNT;
  logic       LEVEL_OUT;
  logic       PULSE_OUT;
  logic [7:0] PRESS_COUNT;

  // Wrapper / stimulus side
  modport master (
    output BTN_IN,
    output CLR_COUNT,
    input  LEVEL_OUT,
    input  PULSE_OUT,
    input  PRESS_COUNT
  );

  // Conditioner side
  modport slave (
    input  BTN_IN,
    input  CLR_COUNT,
    output LEVEL_OUT,
    output PULSE_OUT,
    output PRESS_COUNT
  );
endinterface

// File: rtl/btn_debounce_intr.sv
// rtl/btn_debounce_intr.sv - push-button synchroniser, debouncer, one-shot and press counter
module btn_debounce_intr #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ONESHOT_CYCLES  = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                CLK,
  input  logic                RESET,
  btn_debounce_intr_if.slave  bus
);

  localparam int PCNT_W = $clog2(ONESHOT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(ONESHOT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic               accept;
  logic               sync1_q, btn_s;
  logic [PCNT_W-1:0]  pcnt_q;
  logic               pulse_q;
  logic               level_q;
  logic [7:0]         count_q;

  // Two-stage synchroniser; only btn_s is seen by the debouncer
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync1_q <= bus.BTN_IN;
      btn_s   <= sync1_q;
    end
  end

  // Debounce state and stability counter registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state: a level change is accepted only after an unbroken stable run
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = WAIT_PRESS;
          dcnt_d  = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = WAIT_RELEASE;
          dcnt_d  = '0;
        end
      end
      WAIT_RELEASE: begin
        // A bounce back high during release is still the same press
        if (btn_s) begin
          state_d = PRESSED;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-shot: reload on accept (extends a running pulse), else count down
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      if (accept) begin
        pcnt_q <= PCNT_LOAD;
      end else if (pcnt_q != '0) begin
        pcnt_q <= pcnt_q - PCNT_W'(1);
      end
      pulse_q <= (pcnt_q != '0);
    end
  end

  // Debounced level, registered from state so it rises with the pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      level_q <= 1'b0;
    end else begin
      level_q <= (state_q == PRESSED) || (state_q == WAIT_RELEASE);
    end
  end

  // Press counter; clear takes priority over a same-edge accept
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else if (bus.CLR_COUNT) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign bus.LEVEL_OUT   = level_q;
  assign bus.PULSE_OUT   = pulse_q;
  assign bus.PRESS_COUNT = count_q;

endmodule

// File: tb/tb_btn_debounce_intr.sv
// tb/tb_btn_debounce_intr.sv - self-checking bench for btn_debounce_intr
module tb_btn_debounce_intr;

  localparam int DB = 8;
  localparam int OS = 4;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  btn_debounce_intr_if bus ();

  btn_debounce_intr #(
    .DEBOUNCE_CYCLES(DB),
    .ONESHOT_CYCLES (OS)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: a press/release is accepted once the synchronised
  // input has shown DB+1 consecutive samples opposite to the accepted level.
  logic        m_valid = 1'b0;
  logic        m_s1, m_s2;
  logic [DB:0] m_hist;
  logic [DB:0] m_nh;
  logic        m_deb, m_lvl, m_exp_pulse, m_acc, m_rel;
  logic [7:0]  m_cnt;
  int          m_age;

  assign m_nh  = {m_hist[DB-1:0], m_s2};
  assign m_acc = !m_deb && (&m_nh);
  assign m_rel = m_deb && !(|m_nh);

  always @(posedge CLK) begin
    if (RESET) begin
      m_valid     <= 1'b1;
      m_s1        <= 1'b0;
      m_s2        <= 1'b0;
      m_hist      <= '0;
      m_deb       <= 1'b0;
      m_lvl       <= 1'b0;
      m_cnt       <= 8'd0;
      m_age       <= 1000;
      m_exp_pulse <= 1'b0;
    end else begin
      m_s1        <= bus.BTN_IN;
      m_s2        <= m_s1;
      m_hist      <= m_nh;
      m_deb       <= m_acc ? 1'b1 : (m_rel ? 1'b0 : m_deb);
      m_lvl       <= m_deb;
      m_cnt       <= bus.CLR_COUNT ? 8'd0 : (m_acc ? m_cnt + 8'd1 : m_cnt);
      m_exp_pulse <= (m_age < OS);
      m_age       <= m_acc ? 0 : ((m_age < 1000) ? m_age + 1 : m_age);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (m_valid) begin
      check("model_level", {7'd0, bus.LEVEL_OUT}, {7'd0, m_lvl});
      check("model_pulse", {7'd0, bus.PULSE_OUT}, {7'd0, m_exp_pulse});
      check("model_count", bus.PRESS_COUNT, m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press();
    bus.BTN_IN = 1'b1;
    tick(14);
    bus.BTN_IN = 1'b0;
    tick(14);
  endtask

  initial begin
    RESET         = 1'b1;
    bus.BTN_IN    = 1'b0;
    bus.CLR_COUNT = 1'b0;
    tick(2);
    check("rst_level", {7'd0, bus.LEVEL_OUT}, 8'd0);
    check("rst_pulse", {7'd0, bus.PULSE_OUT}, 8'd0);
    check("rst_count", bus.PRESS_COUNT, 8'd0);
    RESET = 1'b0;
    tick(5);

    // Clean press: accept at edge 10, level/pulse at edge 11, pulse 4 wide
    bus.BTN_IN = 1'b1;
    tick(11);
    check("t1_level_e10", {7'd0, bus.LEVEL_OUT}, 8'd0);
    check("t1_count_e10", bus.PRESS_COUNT, 8'd1);
    tick(1);
    check("t1_level_e11", {7'd0, bus.LEVEL_OUT}, 8'd1);
    check("t1_pulse_e11", {7'd0, bus.PULSE_OUT}, 8'd1);
    tick(3);
    check("t1_pulse_e14", {7'd0, bus.PULSE_OUT}, 8'd1);
    tick(1);
    check("t1_pulse_e15", {7'd0, bus.PULSE_OUT}, 8'd0);
    tick(25);
    bus.BTN_IN = 1'b0;
    tick(11);
    check("t1_rel_e10", {7'd0, bus.LEVEL_OUT}, 8'd1);
    tick(1);
    check("t1_rel_e11", {7'd0, bus.LEVEL_OUT}, 8'd0);
    tick(8);

    // Press bounce then stable high
    for (int i = 0; i < 8; i++) begin
      bus.BTN_IN = (i % 2 == 0);
      tick(3);
    end
    check("t2_no_accept", bus.PRESS_COUNT, 8'd1);
    bus.BTN_IN = 1'b1;
    tick(11);
    check("t2_level_e10", {7'd0, bus.LEVEL_OUT}, 8'd0);
    tick(1);
    check("t2_level_e11", {7'd0, bus.LEVEL_OUT}, 8'd1);
    check("t2_count", bus.PRESS_COUNT, 8'd2);
    tick(20);

    // Release bounce: short low is ignored, long low releases
    bus.BTN_IN = 1'b0;
    tick(5);
    bus.BTN_IN = 1'b1;
    tick(20);
    check("t3_level_held", {7'd0, bus.LEVEL_OUT}, 8'd1);
    check("t3_count_same", bus.PRESS_COUNT, 8'd2);
    bus.BTN_IN = 1'b0;
    tick(11);
    check("t3_rel_e10", {7'd0, bus.LEVEL_OUT}, 8'd1);
    tick(1);
    check("t3_rel_e11", {7'd0, bus.LEVEL_OUT}, 8'd0);
    tick(8);

    // Short press is rejected
    bus.BTN_IN = 1'b1;
    tick(7);
    bus.BTN_IN = 1'b0;
    tick(20);
    check("t4_level", {7'd0, bus.LEVEL_OUT}, 8'd0);
    check("t4_count", bus.PRESS_COUNT, 8'd2);

    // Counter clear and wrap
    bus.CLR_COUNT = 1'b1;
    tick(1);
    bus.CLR_COUNT = 1'b0;
    check("t5_clear", bus.PRESS_COUNT, 8'd0);
    for (int i = 0; i < 256; i++) press();
    check("t5_wrap", bus.PRESS_COUNT, 8'd0);
    press();
    check("t5_one", bus.PRESS_COUNT, 8'd1);
    bus.BTN_IN = 1'b1;
    tick(10);
    bus.CLR_COUNT = 1'b1;
    tick(1);
    bus.CLR_COUNT = 1'b0;
    check("t5_clr_wins", bus.PRESS_COUNT, 8'd0);
    tick(1);
    check("t5_pulse_e11", {7'd0, bus.PULSE_OUT}, 8'd1);
    tick(3);
    check("t5_pulse_e14", {7'd0, bus.PULSE_OUT}, 8'd1);
    tick(1);
    check("t5_pulse_e15", {7'd0, bus.PULSE_OUT}, 8'd0);
    bus.BTN_IN = 1'b0;
    tick(20);

    // Reset during WAIT_PRESS with the button held through it
    press();
    check("t6_pre_count", bus.PRESS_COUNT, 8'd1);
    bus.BTN_IN = 1'b1;
    tick(5);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("t6a_level", {7'd0, bus.LEVEL_OUT}, 8'd0);
    check("t6a_count", bus.PRESS_COUNT, 8'd0);
    tick(10);
    check("t6a_count_r10", bus.PRESS_COUNT, 8'd0);
    tick(1);
    check("t6a_pulse_r11", {7'd0, bus.PULSE_OUT}, 8'd0);
    check("t6a_count_r11", bus.PRESS_COUNT, 8'd1);
    tick(1);
    check("t6a_pulse_r12", {7'd0, bus.PULSE_OUT}, 8'd1);

    // Reset during an active pulse, button still held
    tick(1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("t6b_level", {7'd0, bus.LEVEL_OUT}, 8'd0);
    check("t6b_pulse", {7'd0, bus.PULSE_OUT}, 8'd0);
    check("t6b_count", bus.PRESS_COUNT, 8'd0);
    tick(11);
    check("t6b_pulse_r11", {7'd0, bus.PULSE_OUT}, 8'd0);
    tick(1);
    check("t6b_pulse_r12", {7'd0, bus.PULSE_OUT}, 8'd1);
    check("t6b_level_r12", {7'd0, bus.LEVEL_OUT}, 8'd1);
    check("t6b_count_r12", bus.PRESS_COUNT, 8'd1);
    tick(5);
    bus.BTN_IN = 1'b0;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
